// File: rtl/dbf_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbf_scan_ctrl_pkg
// Description : Shared state encoding and default widths for the DBF
//               per-frame scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dbf_scan_ctrl_pkg;

  localparam int DBF_ADDR_WD   = 10;
  localparam int DBF_LINE_WD   = 8;
  localparam int DBF_TX_WD     = 8;
  localparam int DBF_RX_WD     = 14;
  localparam int DBF_GUARD_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TX    = 3'd2,
    ST_GUARD = 3'd3,
    ST_RX    = 3'd4,
    ST_NEXT  = 3'd5
  } dbf_state_e;

endpackage
`default_nettype wire

// File: rtl/dbf_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dbf_scan_ctrl_if
// Description : Frame command, LUT stream and channel-array strobes of the
//               DBF scan sequencer. master = host/channel side,
//               slave = the sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface dbf_scan_ctrl_if
  import dbf_scan_ctrl_pkg::*;
#(
  parameter int ADDR_WD = DBF_ADDR_WD,
  parameter int LINE_WD = DBF_LINE_WD,
  parameter int TX_WD   = DBF_TX_WD,
  parameter int RX_WD   = DBF_RX_WD
) ();

  logic               frame_go;
  logic               abort;
  logic [LINE_WD-1:0] num_lines;
  logic [ADDR_WD-1:0] lut_len;
  logic [TX_WD-1:0]   tx_cycles;
  logic [RX_WD-1:0]   rx_samples;
  logic               lut_wr_valid;
  logic               lut_wr_ready;
  logic [ADDR_WD-1:0] dbf_lut_addr;
  logic               dbf_lut_we;
  logic               tx_en;
  logic               start;
  logic [LINE_WD-1:0] line_idx;
  logic               busy;
  logic               frame_done;

  modport master (
    output frame_go, abort, num_lines, lut_len, tx_cycles, rx_samples,
           lut_wr_valid,
    input  lut_wr_ready, dbf_lut_addr, dbf_lut_we, tx_en, start, line_idx,
           busy, frame_done
  );

  modport slave (
    input  frame_go, abort, num_lines, lut_len, tx_cycles, rx_samples,
           lut_wr_valid,
    output lut_wr_ready, dbf_lut_addr, dbf_lut_we, tx_en, start, line_idx,
           busy, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/dbf_win_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dbf_win_cnt
// Description : Loadable window down-counter. A load of 0 is treated as 1 so
//               a window is never empty; done is high in the last cycle of
//               the window.
// Revision    : 1.0 - initial release
// ============================================================================
module dbf_win_cnt #(
  parameter int WD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [WD-1:0] load_val,
  input  logic          dec,
  output logic          done
);

  logic [WD-1:0] cnt_q;
  logic [WD-1:0] cnt_d;

  // Load takes priority over decrement; count parks at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? WD'(1) : load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WD'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == WD'(1));

endmodule
`default_nettype wire

// File: rtl/dbf_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dbf_scan_ctrl
// Description : Per-frame DBF scan sequencer. Per line: load delay LUTs from
//               an upstream stream, hold the transmit window, optionally
//               wait a ring-down guard gap, then run the receive window.
//               Optional feature macro: DBF_GUARD_EN (inserts a GUARD_CYC
//               clock quiet gap between TX and RX).
// Revision    : 1.0 - initial release
// ============================================================================
module dbf_scan_ctrl
  import dbf_scan_ctrl_pkg::*;
#(
  parameter int ADDR_WD   = DBF_ADDR_WD,
  parameter int LINE_WD   = DBF_LINE_WD,
  parameter int TX_WD     = DBF_TX_WD,
  parameter int RX_WD     = DBF_RX_WD,
  parameter int GUARD_CYC = DBF_GUARD_CYC
) (
  input  logic           clk,
  input  logic           rst_n,
  dbf_scan_ctrl_if.slave bus
);

  dbf_state_e         state_q,      state_d;
  logic [LINE_WD-1:0] num_lines_q,  num_lines_d;
  logic [LINE_WD-1:0] line_idx_q,   line_idx_d;
  logic [ADDR_WD-1:0] lut_len_q,    lut_len_d;
  logic [ADDR_WD-1:0] load_cnt_q,   load_cnt_d;
  logic [ADDR_WD-1:0] addr_q,       addr_d;
  logic [TX_WD-1:0]   tx_len_q,     tx_len_d;
  logic [RX_WD-1:0]   rx_len_q,     rx_len_d;
  logic               load_last_q,  load_last_d;
  logic               we_q,         we_d;
  logic               ready_q,      ready_d;
  logic               tx_en_q,      tx_en_d;
  logic               start_q,      start_d;
  logic               busy_q,       busy_d;
  logic               frame_done_q, frame_done_d;

  logic tx_load, tx_done;
  logic rx_load, rx_done;

  // Windows are loaded on the edge that enters their state
  assign tx_load = (state_d == ST_TX) && (state_q != ST_TX);
  assign rx_load = (state_d == ST_RX) && (state_q != ST_RX);

  dbf_win_cnt #(.WD(TX_WD)) u_tx_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .load_val (tx_len_q),
    .dec      (state_q == ST_TX),
    .done     (tx_done)
  );

  dbf_win_cnt #(.WD(RX_WD)) u_rx_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rx_load),
    .load_val (rx_len_q),
    .dec      (state_q == ST_RX),
    .done     (rx_done)
  );

`ifdef DBF_GUARD_EN
  localparam int GUARD_WD = (GUARD_CYC < 2) ? 1 : $clog2(GUARD_CYC + 1);

  logic guard_load, guard_done;

  assign guard_load = (state_d == ST_GUARD) && (state_q != ST_GUARD);

  dbf_win_cnt #(.WD(GUARD_WD)) u_guard_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (guard_load),
    .load_val (GUARD_WD'(GUARD_CYC)),
    .dec      (state_q == ST_GUARD),
    .done     (guard_done)
  );
`else
  logic [31:0] unused_guard_cyc;
  assign unused_guard_cyc = 32'(GUARD_CYC);
`endif

  // Next-state decode; every output is derived from the next state so it
  // lands in a register and lines up with the state it belongs to
  always_comb begin
    state_d      = state_q;
    num_lines_d  = num_lines_q;
    line_idx_d   = line_idx_q;
    lut_len_d    = lut_len_q;
    load_cnt_d   = load_cnt_q;
    load_last_d  = load_last_q;
    addr_d       = addr_q;
    tx_len_d     = tx_len_q;
    rx_len_d     = rx_len_q;
    we_d         = 1'b0;
    frame_done_d = 1'b0;

    if (bus.abort) begin
      // Abort beats a coincident frame_go; line_idx keeps the aborted line
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_go) begin
            state_d     = ST_LOAD;
            num_lines_d = (bus.num_lines == '0) ? LINE_WD'(1) : bus.num_lines;
            lut_len_d   = bus.lut_len;
            tx_len_d    = bus.tx_cycles;
            rx_len_d    = bus.rx_samples;
            line_idx_d  = '0;
            addr_d      = '0;
            load_cnt_d  = '0;
            load_last_d = 1'b0;
          end
        end

        ST_LOAD: begin
          if (load_last_q) begin
            // Extra cycle lets the final write strobe finish inside LOAD
            state_d = ST_TX;
            addr_d  = '0;
          end else if (bus.lut_wr_valid && ready_q) begin
            we_d       = 1'b1;
            addr_d     = load_cnt_q;
            load_cnt_d = load_cnt_q + ADDR_WD'(1);
            if (load_cnt_q == lut_len_q) begin
              load_last_d = 1'b1;
            end
          end
        end

        ST_TX: begin
          addr_d = '0;
          if (tx_done) begin
`ifdef DBF_GUARD_EN
            state_d = ST_GUARD;
`else
            state_d = ST_RX;
`endif
          end
        end

`ifdef DBF_GUARD_EN
        ST_GUARD: begin
          if (guard_done) begin
            state_d = ST_RX;
          end
        end
`endif

        ST_RX: begin
          if (rx_done) begin
            state_d = ST_NEXT;
          end else if (addr_q < lut_len_q) begin
            // Read address walks the LUT and parks on the last entry
            addr_d = addr_q + ADDR_WD'(1);
          end
        end

        ST_NEXT: begin
          if (line_idx_q == (num_lines_q - LINE_WD'(1))) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            line_idx_d  = line_idx_q + LINE_WD'(1);
            state_d     = ST_LOAD;
            addr_d      = '0;
            load_cnt_d  = '0;
            load_last_d = 1'b0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ready_d = (state_d == ST_LOAD) && !load_last_d;
    tx_en_d = (state_d == ST_TX);
    start_d = (state_d == ST_RX);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, latched frame configuration and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_lines_q  <= '0;
      line_idx_q   <= '0;
      lut_len_q    <= '0;
      load_cnt_q   <= '0;
      load_last_q  <= 1'b0;
      addr_q       <= '0;
      tx_len_q     <= '0;
      rx_len_q     <= '0;
      we_q         <= 1'b0;
      ready_q      <= 1'b0;
      tx_en_q      <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_lines_q  <= num_lines_d;
      line_idx_q   <= line_idx_d;
      lut_len_q    <= lut_len_d;
      load_cnt_q   <= load_cnt_d;
      load_last_q  <= load_last_d;
      addr_q       <= addr_d;
      tx_len_q     <= tx_len_d;
      rx_len_q     <= rx_len_d;
      we_q         <= we_d;
      ready_q      <= ready_d;
      tx_en_q      <= tx_en_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.lut_wr_ready = ready_q;
  assign bus.dbf_lut_addr = addr_q;
  assign bus.dbf_lut_we   = we_q;
  assign bus.tx_en        = tx_en_q;
  assign bus.start        = start_q;
  assign bus.line_idx     = line_idx_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dbf_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbf_scan_ctrl
// Description : Directed self-checking bench for dbf_scan_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbf_scan_ctrl;
  import dbf_scan_ctrl_pkg::*;

`ifdef DBF_GUARD_EN
  localparam int EXP_GAP = DBF_GUARD_CYC;
`else
  localparam int EXP_GAP = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dbf_scan_ctrl_if bus ();

  dbf_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int we_addrs[$];
  int rx_addrs[$];
  int tx_runs[$];
  int st_runs[$];
  int gaps[$];
  int tx_len, st_len, tx_fall, first_tx, go_cyc;
  int fd_cnt, fd_line, fd_busy, overlap, we_bad, stall_bad, rdy_cnt;
  int prev_addr = 0;
  bit prev_tx   = 1'b0;
  bit prev_st   = 1'b0;
  bit prev_rdy  = 1'b0;
  bit pat_mode  = 1'b0;
  int pidx      = 0;
  bit inject_go = 1'b0;
  int abort_at  = 0;
  logic [3:0] pat = 4'b1001;

  int exp_we[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_rx[8] = '{0, 1, 2, 3, 3, 3, 3, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clear_log();
    we_addrs.delete();
    rx_addrs.delete();
    tx_runs.delete();
    st_runs.delete();
    gaps.delete();
    tx_len = 0; st_len = 0; tx_fall = cyc; first_tx = -1; go_cyc = 0;
    fd_cnt = 0; fd_line = -1; fd_busy = -1; overlap = 0; we_bad = 0;
    stall_bad = 0; rdy_cnt = 0;
  endtask

  // One clock: sample just after the edge, log activity, drive next inputs
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.dbf_lut_we) begin
      we_addrs.push_back(int'(bus.dbf_lut_addr));
      if (!bus.lut_wr_valid || !bus.busy) we_bad++;
    end
    if (bus.lut_wr_ready) begin
      rdy_cnt++;
      if (prev_rdy && !bus.dbf_lut_we && int'(bus.dbf_lut_addr) != prev_addr) stall_bad++;
    end
    if (bus.tx_en) begin
      tx_len++;
      if (!prev_tx && first_tx < 0) first_tx = cyc;
    end
    if (prev_tx && !bus.tx_en) begin
      tx_runs.push_back(tx_len);
      tx_len  = 0;
      tx_fall = cyc;
    end
    if (bus.start) begin
      st_len++;
      rx_addrs.push_back(int'(bus.dbf_lut_addr));
      if (!prev_st) gaps.push_back(cyc - tx_fall);
    end
    if (prev_st && !bus.start) begin
      st_runs.push_back(st_len);
      st_len = 0;
    end
    if (bus.tx_en && bus.start) overlap++;
    if (bus.frame_done) begin
      fd_cnt++;
      fd_line = int'(bus.line_idx);
      fd_busy = int'(bus.busy);
    end
    prev_tx   = bus.tx_en;
    prev_st   = bus.start;
    prev_rdy  = bus.lut_wr_ready;
    prev_addr = int'(bus.dbf_lut_addr);

    bus.frame_go = 1'b0;
    if (inject_go && bus.tx_en) begin
      bus.frame_go   = 1'b1;
      bus.num_lines  = 8'd7;
      bus.tx_cycles  = 8'd2;
      inject_go      = 1'b0;
    end
    bus.abort = 1'b0;
    if (abort_at > 0 && bus.start && st_len == abort_at) begin
      bus.abort = 1'b1;
      abort_at  = 0;
    end
    if (pat_mode) begin
      if (bus.lut_wr_ready) begin
        bus.lut_wr_valid = pat[pidx % 4];
        pidx++;
      end else begin
        bus.lut_wr_valid = 1'b0;
      end
    end else begin
      bus.lut_wr_valid = 1'b1;
    end
  endtask

  task automatic go(input int nl, input int ll, input int txc, input int rxc);
    bus.num_lines  = DBF_LINE_WD'(nl);
    bus.lut_len    = DBF_ADDR_WD'(ll);
    bus.tx_cycles  = DBF_TX_WD'(txc);
    bus.rx_samples = DBF_RX_WD'(rxc);
    bus.frame_go   = 1'b1;
    tick();
    go_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (fd_cnt == 0 && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(fd_cnt), 1);
  endtask

  initial begin
    bus.frame_go     = 1'b0;
    bus.abort        = 1'b0;
    bus.num_lines    = '0;
    bus.lut_len      = '0;
    bus.tx_cycles    = '0;
    bus.rx_samples   = '0;
    bus.lut_wr_valid = 1'b1;
    clear_log();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     32'(bus.busy),         0);
    check("rst_ready",    32'(bus.lut_wr_ready), 0);
    check("rst_we",       32'(bus.dbf_lut_we),   0);
    check("rst_addr",     32'(bus.dbf_lut_addr), 0);
    check("rst_tx_en",    32'(bus.tx_en),        0);
    check("rst_start",    32'(bus.start),        0);
    check("rst_line_idx", 32'(bus.line_idx),     0);
    check("rst_fdone",    32'(bus.frame_done),   0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    // Test 1: two lines, LUT of 4, tx 5, rx 8, valid tied high
    clear_log();
    go(2, 3, 5, 8);
    check("t1_busy_after_go", 32'(bus.busy),         1);
    check("t1_ready_after_go", 32'(bus.lut_wr_ready), 1);
    wait_done("t1_done", 200);
    repeat (4) tick();
    check("t1_fd_count", 32'(fd_cnt), 1);
    check("t1_fd_line",  32'(fd_line), 1);
    check("t1_fd_busy",  32'(fd_busy), 0);
    check("t1_we_count", 32'(we_addrs.size()), 8);
    for (int k = 0; k < 8 && k < we_addrs.size(); k++)
      check($sformatf("t1_we_addr%0d", k), we_addrs[k], exp_we[k]);
    check("t1_tx_runs", 32'(tx_runs.size()), 2);
    for (int k = 0; k < tx_runs.size(); k++)
      check($sformatf("t1_tx_len%0d", k), tx_runs[k], 5);
    check("t1_st_runs", 32'(st_runs.size()), 2);
    for (int k = 0; k < st_runs.size(); k++)
      check($sformatf("t1_st_len%0d", k), st_runs[k], 8);
    check("t1_rx_count", 32'(rx_addrs.size()), 16);
    for (int k = 0; k < 16 && k < rx_addrs.size(); k++)
      check($sformatf("t1_rx_addr%0d", k), rx_addrs[k], exp_rx[k % 8]);
    check("t1_overlap", 32'(overlap), 0);
    check("t1_we_bad",  32'(we_bad), 0);
    check("t1_ready_cycles", 32'(rdy_cnt), 8);
    check("t1_tx_latency", 32'(first_tx - go_cyc), 5);

    // Test 6: TX->RX gap, one per line
    check("t6_gap_count", 32'(gaps.size()), 2);
    for (int k = 0; k < gaps.size(); k++)
      check($sformatf("t6_gap%0d", k), gaps[k], EXP_GAP);

    // Test 2: upstream valid pattern 1,0,0,1 during LOAD
    clear_log();
    pat_mode = 1'b1;
    pidx     = 0;
    go(1, 3, 2, 2);
    wait_done("t2_done", 200);
    pat_mode = 1'b0;
    tick();
    check("t2_we_count", 32'(we_addrs.size()), 4);
    for (int k = 0; k < 4 && k < we_addrs.size(); k++)
      check($sformatf("t2_we_addr%0d", k), we_addrs[k], k);
    check("t2_stall_addr", 32'(stall_bad), 0);
    check("t2_we_bad",     32'(we_bad), 0);
    check("t2_ready_cycles", 32'(rdy_cnt), 8);

    // Test 3: abort on the 3rd RX clock of line 0
    clear_log();
    abort_at = 3;
    go(2, 3, 5, 8);
    begin : b_wait_abort
      int i;
      i = 0;
      while (bus.abort == 1'b0 && i < 100) begin
        tick();
        i++;
      end
    end
    check("t3_abort_fired", 32'(bus.abort), 1);
    tick();
    check("t3_start",    32'(bus.start),        0);
    check("t3_busy",     32'(bus.busy),         0);
    check("t3_tx_en",    32'(bus.tx_en),        0);
    check("t3_ready",    32'(bus.lut_wr_ready), 0);
    check("t3_line_idx", 32'(bus.line_idx),     0);
    check("t3_st_len",   32'(st_runs.size() > 0 ? st_runs[0] : -1), 3);
    repeat (20) tick();
    check("t3_no_fdone", 32'(fd_cnt), 0);
    check("t3_still_idle", 32'(bus.busy), 0);

    // abort together with frame_go in IDLE: abort wins
    bus.abort    = 1'b1;
    bus.frame_go = 1'b1;
    tick();
    check("t3_abort_go_busy",  32'(bus.busy),         0);
    check("t3_abort_go_ready", 32'(bus.lut_wr_ready), 0);

    // Restart after abort
    clear_log();
    go(2, 3, 5, 8);
    check("t3_restart_line", 32'(bus.line_idx), 0);
    check("t3_restart_busy", 32'(bus.busy), 1);
    wait_done("t3_restart_done", 200);
    check("t3_restart_fd_line", 32'(fd_line), 1);

    // Test 4: frame_go (with different config) pulsed during TX is ignored
    clear_log();
    inject_go = 1'b1;
    go(2, 3, 5, 8);
    wait_done("t4_done", 200);
    repeat (4) tick();
    check("t4_fd_count", 32'(fd_cnt), 1);
    check("t4_fd_line",  32'(fd_line), 1);
    check("t4_we_count", 32'(we_addrs.size()), 8);
    check("t4_tx_runs",  32'(tx_runs.size()), 2);
    for (int k = 0; k < tx_runs.size(); k++)
      check($sformatf("t4_tx_len%0d", k), tx_runs[k], 5);
    check("t4_st_runs",  32'(st_runs.size()), 2);
    for (int k = 0; k < st_runs.size(); k++)
      check($sformatf("t4_st_len%0d", k), st_runs[k], 8);
    check("t4_overlap", 32'(overlap), 0);

    // Test 5: zero lengths are treated as one
    clear_log();
    go(0, 0, 0, 0);
    wait_done("t5_done", 100);
    repeat (4) tick();
    check("t5_fd_count", 32'(fd_cnt), 1);
    check("t5_fd_line",  32'(fd_line), 0);
    check("t5_we_count", 32'(we_addrs.size()), 1);
    check("t5_tx_runs",  32'(tx_runs.size()), 1);
    check("t5_tx_len",   32'(tx_runs.size() > 0 ? tx_runs[0] : -1), 1);
    check("t5_st_runs",  32'(st_runs.size()), 1);
    check("t5_st_len",   32'(st_runs.size() > 0 ? st_runs[0] : -1), 1);
    check("t5_tx_latency", 32'(first_tx - go_cyc), 2);

    // Reset in the middle of TX
    clear_log();
    go(2, 3, 5, 8);
    begin : b_wait_tx
      int i;
      i = 0;
      while (bus.tx_en == 1'b0 && i < 100) begin
        tick();
        i++;
      end
    end
    check("t7_tx_seen", 32'(bus.tx_en), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy",  32'(bus.busy),  0);
    check("t7_rst_tx_en", 32'(bus.tx_en), 0);
    check("t7_rst_ready", 32'(bus.lut_wr_ready), 0);
    check("t7_rst_addr",  32'(bus.dbf_lut_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbf_scan_ctrl.md
Name: dbf_scan_ctrl

Overview:
Per-frame sequencer for the DBF channel array. It sits above the 32 dbf_chNN instances and drives their shared `dbf_lut_addr`, `dbf_lut_we`, `tx_en` and `start` inputs. For each scan line it runs three steps in order: load the coarse/fine delay LUTs from an upstream stream, hold the transmit window, then open the receive/beamform window. It repeats this for `num_lines` lines and then reports frame completion.

Parameters:
ADDR_WD, 10, width of the delay-LUT address bus shared by all channels
LINE_WD, 8, width of the line counter and `num_lines`
TX_WD, 8, width of the transmit-window length
RX_WD, 14, width of the receive-window sample count
GUARD_CYC, 4, TX->RX guard gap in clocks (used only with DBF_GUARD_EN)

Ports:
clk  in  1  system clock, 40 MHz
rst_n  in  1  asynchronous active-low reset
frame_go  in  1  one-cycle pulse that starts a frame; ignored while busy
abort  in  1  synchronous abort; highest priority
num_lines  in  LINE_WD  lines per frame; sampled on frame_go; 0 is treated as 1
lut_len  in  ADDR_WD  LUT entries per line minus 1; sampled on frame_go
tx_cycles  in  TX_WD  tx_en high time in clocks; sampled on frame_go; 0 is treated as 1
rx_samples  in  RX_WD  start high time in clocks; sampled on frame_go; 0 is treated as 1
lut_wr_valid  in  1  upstream LUT word available
lut_wr_ready  out  1  controller accepts an LUT word this cycle
dbf_lut_addr  out  ADDR_WD  LUT write address during LOAD, read address during RX
dbf_lut_we  out  1  LUT write strobe to all channels
tx_en  out  1  transmit window; channels discard input while high
start  out  1  beamform enable to all channels
line_idx  out  LINE_WD  index of the current line
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse after the last line completes

Behaviour:
- All outputs are registered. Reset value of every output is 0; state resets to IDLE.
- States: IDLE, LOAD, TX, GUARD (only with DBF_GUARD_EN), RX, NEXT.
- IDLE -> LOAD on frame_go:
  - latch num_lines, lut_len, tx_cycles, rx_samples;
  - clear line_idx and addr.
- LOAD:
  - lut_wr_ready=1.
  - Each cycle with lut_wr_valid&lut_wr_ready: dbf_lut_we=1 on the next edge, addr=current count, count+1.
  - After the write at count==lut_len -> TX. dbf_lut_we must drop the same cycle state leaves LOAD.
  - Stalls with no timeout while valid is low; hold address.
- TX: tx_en=1 for exactly tx_cycles clocks, addr=0, then -> RX (or GUARD).
- GUARD: all strobes low for GUARD_CYC clocks -> RX.
- RX:
  - start=1 for exactly rx_samples clocks.
  - dbf_lut_addr increments by 1 each cycle from 0; saturates at lut_len (no wrap).
  - Then -> NEXT.
- NEXT (1 clock):
  - if line_idx==num_lines-1: frame_done=1, -> IDLE;
  - else line_idx+1, -> LOAD.
- tx_en and start are never high in the same cycle. dbf_lut_we is never high outside LOAD.
- First tx_en rises at least lut_len+2 clocks after frame_go (zero upstream stalls).
- abort from any state:
  - next cycle: state=IDLE, all strobes 0, no frame_done pulse;
  - line_idx holds its last value for debug.
  - abort together with frame_go in IDLE: abort wins.
- frame_go while busy is ignored, with no side effects.
- Reset mid-operation: immediate return to reset values regardless of state.
- Counters are sized to their parameter widths; lengths use unsigned compare.

Optional Feature:
DBF_GUARD_EN.
- Defined: GUARD state inserted between TX and RX for GUARD_CYC clocks, with tx_en=start=0 during it. This allows transducer ring-down.
- Undefined: TX goes directly to RX; start rises the clock after tx_en falls. GUARD_CYC is unused.

Decomposition:
- Shared package/`include` (alongside define.v / param.h): state encoding constants (ST_IDLE..ST_NEXT), default widths ADDR_WD/LINE_WD/TX_WD/RX_WD.
- One natural sub-module: dbf_win_cnt, a loadable down-counter with a done flag, instantiated for the TX, GUARD and RX windows.

Test Plan:
1. num_lines=2, lut_len=3, tx_cycles=5, rx_samples=8, valid tied high -> per line:
   - exactly 4 we pulses at addr 0,1,2,3;
   - tx_en high for 5 clks, start high for 8 clks, addr in RX runs 0,1,2,3,3,3,3,3;
   - single frame_done after line_idx=1.
2. lut_wr_valid toggling 1,0,0,1 during LOAD -> ready held, addr frozen during stalls, we only on valid cycles, total 4 writes.
3. abort asserted on the 3rd clk of RX in line 0 -> next clk: start=0, busy=0, no frame_done; a later frame_go restarts from line_idx 0.
4. frame_go pulsed during TX -> ignored; frame completes identically to test 1.
5. tx_cycles=0, rx_samples=0, num_lines=0 -> one line, 1-clk tx_en, 1-clk start, frame_done asserted.
6. With DBF_GUARD_EN and GUARD_CYC=4 -> exactly 4 clks with tx_en=start=0 between tx_en fall and start rise; without the macro the gap is 0 clks.
